// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: defaults, FSM encoding and the
// bit-reverse helper used to scatter loaded samples.
package fft_pkg;

  localparam int N_POINTS_DEF       = 1024;
  localparam int RAM_RD_LATENCY_DEF = 2;
  localparam int BFU_LATENCY_DEF    = 4;
  localparam int MAX_L              = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_DRAIN,
    ST_STAGE_RUN,
    ST_STAGE_DRAIN,
    ST_DONE
  } fsm_state_e;

  // Reverses the low w bits of x; bits above w come back as zero.
  function automatic logic [MAX_L-1:0] bitrev(input logic [MAX_L-1:0] x, input int w);
    logic [MAX_L-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_L; i++)
      if (i < w) r[i] = x[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register that carries a strobe plus its address payload
// from the read issue point to where the data (or write-back) is due.
module fft_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 FFT sequencer: bit-reversed sample load, then L ping-pong
// butterfly stages with read/butterfly/write-back latency tracked by delay lines.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_POINTS       = N_POINTS_DEF,
  parameter int RAM_RD_LATENCY = RAM_RD_LATENCY_DEF,
  parameter int BFU_LATENCY    = BFU_LATENCY_DEF,
  localparam int L             = $clog2(N_POINTS)
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [L-1:0] buf_addr_o,
  output logic         buf_rd_o,
  output logic [L-1:0] rd_addr_a_o,
  output logic [L-1:0] rd_addr_b_o,
  output logic         rd_en_o,
  output logic [L-1:0] wr_addr_a_o,
  output logic [L-1:0] wr_addr_b_o,
  output logic         wr_en_o,
  output logic         load_o,
  output logic         memsel_o,
  output logic [L-2:0] twiddle_addr_o,
  output logic         bfu_valid_o,
  output logic [3:0]   stage_o,
  output logic         result_sel_o
);

  localparam int WR_LAT = RAM_RD_LATENCY + BFU_LATENCY;
  localparam int DW     = $clog2(WR_LAT + 1);
  localparam int TW     = L - 1;

  localparam logic [L-1:0]  LOAD_LAST     = L'(N_POINTS - 1);
  localparam logic [L-1:0]  RUN_LAST      = L'(N_POINTS / 2 - 1);
  localparam logic [DW-1:0] LD_DRAIN_LAST = DW'(RAM_RD_LATENCY - 1);
  localparam logic [DW-1:0] ST_DRAIN_LAST = DW'(WR_LAT - 1);
  localparam logic [3:0]    STAGE_LAST    = 4'(L - 1);

  fsm_state_e state, state_nxt;

  logic [L-1:0]  cnt;
  logic [DW-1:0] dcnt;
  logic [3:0]    stage;
  logic          memsel, result_sel;

  logic load_end, run_end, ld_drain_end, st_drain_end, last_stage;
  logic ld_live, rd_live;

  assign ld_live      = (state == ST_LOAD);
  assign rd_live      = (state == ST_STAGE_RUN);
  assign load_end     = ld_live && (cnt == LOAD_LAST);
  assign run_end      = rd_live && (cnt == RUN_LAST);
  assign ld_drain_end = (state == ST_LOAD_DRAIN)  && (dcnt == LD_DRAIN_LAST);
  assign st_drain_end = (state == ST_STAGE_DRAIN) && (dcnt == ST_DRAIN_LAST);
  assign last_stage   = (stage == STAGE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (start_i)      state_nxt = ST_LOAD;
      ST_LOAD:        if (load_end)     state_nxt = ST_LOAD_DRAIN;
      ST_LOAD_DRAIN:  if (ld_drain_end) state_nxt = ST_STAGE_RUN;
      ST_STAGE_RUN:   if (run_end)      state_nxt = ST_STAGE_DRAIN;
      ST_STAGE_DRAIN: if (st_drain_end) state_nxt = last_stage ? ST_DONE : ST_STAGE_RUN;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // cnt is the load index in LOAD and the butterfly index k in STAGE_RUN;
  // it returns to 0 whenever its window closes, so every stage starts at k=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      dcnt       <= '0;
      stage      <= '0;
      memsel     <= 1'b0;
      result_sel <= 1'b0;
    end else begin
      cnt  <= ((ld_live && !load_end) || (rd_live && !run_end)) ? cnt + 1'b1 : '0;
      dcnt <= ((state == ST_LOAD_DRAIN && !ld_drain_end) ||
               (state == ST_STAGE_DRAIN && !st_drain_end)) ? dcnt + 1'b1 : '0;
      if (state == ST_IDLE && start_i) begin
        stage  <= '0;
        memsel <= 1'b0;
      end else if (st_drain_end) begin
        memsel <= ~memsel;
        if (last_stage) result_sel <= ~memsel;
        else            stage      <= stage + 1'b1;
      end
    end
  end

  logic [L-1:0]  half, pos, grp, addr_a, addr_b, ld_addr;
  logic [TW-1:0] tw;

  always_comb begin
    half    = L'(1) << stage;
    pos     = cnt & (half - 1'b1);
    grp     = cnt >> stage;
    addr_a  = (grp << (stage + 4'd1)) | pos;
    addr_b  = addr_a + half;
    tw      = TW'(pos << (STAGE_LAST - stage));
    ld_addr = L'(bitrev(MAX_L'(cnt), L));
  end

  logic [L+1:0] rv_in, rv_out;
  logic [2*L:0] rw_in, rw_out;

  assign rv_in = {rd_live, ld_live, ld_addr};
  assign rw_in = {rd_live, addr_a, addr_b};

  // Load writes share the read-latency line with bfu_valid; the two never overlap.
  fft_delay_line #(.DEPTH(RAM_RD_LATENCY), .W(L + 2)) u_rd2v (
    .clk  (clk),
    .rst  (rst),
    .din  (rv_in),
    .dout (rv_out)
  );

  fft_delay_line #(.DEPTH(WR_LAT), .W(2 * L + 1)) u_rd2wr (
    .clk  (clk),
    .rst  (rst),
    .din  (rw_in),
    .dout (rw_out)
  );

  logic          ld_wr, st_wr;
  logic [L-1:0]  buf_addr_q, ra_q, rb_q, wa_q, wb_q;
  logic [TW-1:0] tw_q;

  assign ld_wr = rv_out[L];
  assign st_wr = rw_out[2*L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_addr_q <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      tw_q       <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
    end else begin
      buf_addr_q <= buf_addr_o;
      ra_q       <= rd_addr_a_o;
      rb_q       <= rd_addr_b_o;
      tw_q       <= twiddle_addr_o;
      wa_q       <= wr_addr_a_o;
      wb_q       <= wr_addr_b_o;
    end
  end

  always_comb begin
    busy_o         = (state != ST_IDLE);
    done_o         = (state == ST_DONE);
    buf_rd_o       = ld_live;
    buf_addr_o     = ld_live ? cnt : buf_addr_q;
    rd_en_o        = rd_live;
    rd_addr_a_o    = rd_live ? addr_a : ra_q;
    rd_addr_b_o    = rd_live ? addr_b : rb_q;
    twiddle_addr_o = rd_live ? tw : tw_q;
    bfu_valid_o    = rv_out[L+1];
    wr_en_o        = ld_wr | st_wr;
    load_o         = ld_wr;
    wr_addr_a_o    = ld_wr ? rv_out[L-1:0] : (st_wr ? rw_out[2*L-1:L] : wa_q);
    wr_addr_b_o    = st_wr ? rw_out[L-1:0] : wb_q;
    memsel_o       = memsel;
    stage_o        = stage;
    result_sel_o   = result_sel;
  end

endmodule
